// File: rtl/spi_dac_slave.sv
// Receiving end of the DAC serial link: oversampled SPI (CPOL=0, falling-edge sample)
// deserialiser with per-channel input registers and LDAC-transferred DAC output registers.
module spi_dac_slave #(
    parameter int DATA_W = 16,
    parameter int NUM_CH = 4
) (
    input  logic                     sys_clk_i,
    input  logic                     sys_rst_n,
    input  logic                     cs_i,
    input  logic                     scl_i,
    input  logic                     mosi_i,
    input  logic                     ldac_i,
    output logic                     busy_o,
    output logic                     frame_valid_o,
    output logic                     frame_err_o,
    output logic [3:0]               rx_cmd_o,
    output logic [3:0]               rx_addr_o,
    output logic [DATA_W-1:0]        rx_data_o,
    output logic [NUM_CH*DATA_W-1:0] dac_data_o
);

    localparam int FW      = 8 + DATA_W;
    localparam int CNT_MAX = FW + 1;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    // [0],[1] synchroniser, [2] history for edge detection
    logic [2:0] cs_q, scl_q, mosi_q, ldac_q;
    logic [1:0] vld_q;
    logic       armed_q, armed_d;

    state_t            state_q, state_d;
    logic [FW-1:0]     sh_q, sh_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              fv_q, fv_d, fe_q, fe_d;
    logic [3:0]        rx_cmd_q, rx_cmd_d, rx_addr_q, rx_addr_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic [NUM_CH-1:0][DATA_W-1:0] in_q, in_d, dac_q, dac_d;

    logic cs_fall, cs_rise, scl_fall, ldac_fall;
    logic [3:0]        f_cmd, f_addr;
    logic [DATA_W-1:0] f_data;

    // A CS fall is only trusted once a real high level has been synchronised after reset,
    // so the reset value of the CS flops cannot open a phantom frame.
    assign armed_d   = armed_q | (vld_q[1] & cs_q[1]);
    assign cs_fall   = armed_q & cs_q[2] & ~cs_q[1];
    assign cs_rise   = ~cs_q[2] & cs_q[1];
    assign scl_fall  = scl_q[2] & ~scl_q[1];
    assign ldac_fall = ldac_q[2] & ~ldac_q[1];

    assign f_cmd  = sh_q[FW-1 -: 4];
    assign f_addr = sh_q[FW-5 -: 4];
    assign f_data = sh_q[DATA_W-1:0];

    always_ff @(posedge sys_clk_i or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cs_q    <= 3'b111;
            scl_q   <= 3'b000;
            mosi_q  <= 3'b000;
            ldac_q  <= 3'b111;
            vld_q   <= 2'b00;
            armed_q <= 1'b0;
        end else begin
            cs_q    <= {cs_q[1:0], cs_i};
            scl_q   <= {scl_q[1:0], scl_i};
            mosi_q  <= {mosi_q[1:0], mosi_i};
            ldac_q  <= {ldac_q[1:0], ldac_i};
            vld_q   <= {vld_q[0], 1'b1};
            armed_q <= armed_d;
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            sh_q      <= '0;
            cnt_q     <= '0;
            fv_q      <= 1'b0;
            fe_q      <= 1'b0;
            rx_cmd_q  <= '0;
            rx_addr_q <= '0;
            rx_data_q <= '0;
            in_q      <= '0;
            dac_q     <= '0;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            cnt_q     <= cnt_d;
            fv_q      <= fv_d;
            fe_q      <= fe_d;
            rx_cmd_q  <= rx_cmd_d;
            rx_addr_q <= rx_addr_d;
            rx_data_q <= rx_data_d;
            in_q      <= in_d;
            dac_q     <= dac_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        fv_d    = 1'b0;
        fe_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = SHIFT;
                    sh_d    = '0;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                // CS edges take priority over a coincident SCL edge
                if (cs_rise) begin
                    state_d = IDLE;
                    if (cnt_q == CW'(FW)) fv_d = 1'b1;
                    else                  fe_d = 1'b1;
                end else if (cs_fall) begin
                    sh_d  = '0;
                    cnt_d = '0;
                end else if (scl_fall) begin
                    sh_d = {sh_q[FW-2:0], mosi_q[2]};
                    if (cnt_q != CW'(CNT_MAX)) cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rx_cmd_d  = rx_cmd_q;
        rx_addr_d = rx_addr_q;
        rx_data_d = rx_data_q;
        in_d      = in_q;
        dac_d     = dac_q;
        if (fv_d) begin
            rx_cmd_d  = f_cmd;
            rx_addr_d = f_addr;
            rx_data_d = f_data;
            for (int n = 0; n < NUM_CH; n++)
                if (f_addr == 4'(n) && (f_cmd == 4'h0 || f_cmd == 4'h1)) in_d[n] = f_data;
        end
        // LDAC sees the freshly written input register, so a coincident write lands in the DAC
        if (ldac_fall || (fv_d && f_cmd == 4'h2)) dac_d = in_d;
        if (fv_d && f_cmd == 4'h1)
            for (int n = 0; n < NUM_CH; n++)
                if (f_addr == 4'(n)) dac_d[n] = f_data;
    end

    assign busy_o        = (state_q == SHIFT);
    assign frame_valid_o = fv_q;
    assign frame_err_o   = fe_q;
    assign rx_cmd_o      = rx_cmd_q;
    assign rx_addr_o     = rx_addr_q;
    assign rx_data_o     = rx_data_q;
    assign dac_data_o    = dac_q;

endmodule
